sde_h2c_axis_wc: RTL and testbench
==================================

Name: sde_h2c_axis_wc

Overview:
H2C AXI-Stream egress stage of the SDE, placed between the H2C data buffer and the CL user stream.
Down-converts PCIM-width buffer beats to a narrower (or equal) AXIS width, trimming empty trailing slices of the final beat.
Registers all stream outputs.
Maintains the H2C packet counter for CSR readback and write-back.

Parameters:
DESC_TYPE, 0, 0 = regular descriptors, 1 = compact descriptors; selects the USER_BIT_WIDTH default.
PCIM_DATA_WIDTH, 512, buffer-side data width in bits.
AXIS_DATA_WIDTH, 512, user-side data width in bits; legal values 64/128/256/512; must divide PCIM_DATA_WIDTH. Elaboration error otherwise.
USER_BIT_WIDTH, DESC_TYPE ? 1 : 64, sideband user width.
Derived: RATIO = PCIM_DATA_WIDTH/AXIS_DATA_WIDTH (1..8); SLICE_IDX_W = max(1, clog2(RATIO)).

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
cfg_axis_clr_pkt_cnt  in  1  synchronous packet-counter clear (level)
axis_cfg_pkt_cnt  out  32  packet count for CSR
buf_axis_valid  in  1  buffer beat valid
buf_axis_data  in  PCIM_DATA_WIDTH  buffer data
buf_axis_keep  in  PCIM_DATA_WIDTH/8  byte enables, contiguous from LSB
buf_axis_user  in  USER_BIT_WIDTH  sideband
buf_axis_last  in  1  end of packet
axis_buf_ready  out  1  buffer beat accept
h2c_axis_valid  out  1  user beat valid
h2c_axis_data  out  AXIS_DATA_WIDTH  user data
h2c_axis_keep  out  AXIS_DATA_WIDTH/8  byte enables
h2c_axis_user  out  USER_BIT_WIDTH  sideband, replicated on every slice
h2c_axis_last  out  1  end of packet
h2c_axis_ready  in  1  user accept
axis_wb_pkt_cnt_req  out  1  one-cycle write-back pulse
axis_wb_pkt_cnt  out  32  packet count to write-back

Behaviour:
- Reset values: all outputs 0. Holding register empty, slice index 0, counter 0.
- Assertion of rst_n mid-packet discards the held beat and any partially sent packet. No last is generated.
- Holding register (HR) holds one buffer beat plus n_max, the highest slice index with any keep bit set.
  - n_max = 0 when keep is all zero; slice 0 is still emitted, with keep 0.
- States:
  - EMPTY: h2c_axis_valid = 0.
  - SEND: output register presents slice idx of HR.
- Output register contents:
  - data/keep = slice idx of HR.
  - user = HR user.
  - last = HR last AND (idx == n_max).
- Non-last input beats: all RATIO slices are emitted. Keep is expected full; it is passed through unchecked.
- Handshake:
  - Outputs hold stable while valid && !ready.
  - An output beat completes when h2c_axis_valid & h2c_axis_ready.
  - On completion with idx < n_max, idx increments.
  - On completion with idx == n_max, the beat is retired.
- axis_buf_ready = (state == EMPTY) | (output handshake on the final slice). This is combinational from registered state and h2c_axis_ready.
- Accepting a beat loads HR, sets idx = 0, and enters SEND. Retirement without a simultaneous accept enters EMPTY.
- Latency: buffer accept to h2c_axis_valid is 1 clk.
- Throughput: RATIO=1 gives one beat/clk back-to-back; otherwise (n_max+1) clks per input beat.
- Packet counter:
  - Increments on output handshake with h2c_axis_last.
  - cfg_axis_clr_pkt_cnt has priority: a simultaneous increment is lost and the count becomes 0.
  - Wraps 0xFFFF_FFFF -> 0.
- axis_cfg_pkt_cnt = axis_wb_pkt_cnt = counter.
- axis_wb_pkt_cnt_req pulses for 1 clk in the cycle after each last handshake, regardless of clear.

Optional Feature:
SDE_H2C_AXIS_BYTE_CNT_EN
- Defined:
  - Adds output axis_cfg_byte_cnt [63:0]. It accumulates popcount(h2c_axis_keep) on every output handshake.
  - Cleared by cfg_axis_clr_pkt_cnt, with the same priority as the packet counter.
  - Wraps at 2^64; reset value 0.
- Undefined: the port and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package sde_h2c_axis_pkg:
  - state enum typedef (EMPTY, SEND).
  - legal-width constants.
  - function f_ratio.
  - function f_last_slice(keep), returning n_max.
- Sub-module sde_h2c_axis_pkt_cnt: packet counter, write-back pulse, optional byte counter, clear priority.
  - Reusable by the C2H side.

Test Plan:
- RATIO=1, 10 back-to-back single-beat packets, ready tied 1 -> 10 output beats on consecutive clks; pkt_cnt = 10; 10 wb pulses each 1 clk after its last.
- 512->128, 2-beat packet, second beat keep = 0x000F_FFFF (20 B) -> 4 + 2 output beats; final beat keep 0x000F, last = 1; axis_buf_ready low for 3 of every 4 clks on the first beat.
- 512->64, random h2c_axis_ready stalls -> data/keep/last stable while stalled; output stream byte-identical to input; no drops or duplicates.
- Counter preloaded to 0xFFFF_FFFF, then one last handshake -> count 0; clear asserted in the same clk as a last handshake -> count 0 and wb pulse still issued.
- rst_n asserted mid-packet at slice 2 of 4 -> outputs 0 immediately; after release, next packet is emitted from slice 0; count unchanged by the aborted packet.
- SDE_H2C_AXIS_BYTE_CNT_EN, 3 packets of 100 B at 512->256 -> byte_cnt = 300; clear -> 0.

Source files
------------

// File: rtl/sde_h2c_axis_pkg.sv
// sde_h2c_axis_pkg: shared types, width limits and slice helpers for the H2C AXIS egress stage.
package sde_h2c_axis_pkg;
   typedef enum logic {EMPTY, SEND} state_e;
   localparam int AXIS_W_MIN = 64;
   localparam int AXIS_W_MAX = 512;
   localparam int RATIO_MAX = 8;
   localparam int KEEP_MAX = AXIS_W_MAX * RATIO_MAX / 8;

   function automatic int f_ratio(input int pcim_w, input int axis_w);
      return pcim_w / axis_w;
   endfunction

   function automatic logic f_legal_axis(input int w);
      return w >= AXIS_W_MIN && w <= AXIS_W_MAX && (w & (w - 1)) == 0;
   endfunction

   // Highest slice holding any enabled byte; an all-zero keep still maps to slice 0.
   function automatic logic [2:0] f_last_slice(input logic [KEEP_MAX-1:0] keep, input int sb, input int ratio);
      logic [2:0] n;
      n = '0;
      for (int s = 0; s < ratio; s++)
         for (int b = 0; b < sb; b++)
            if (keep[s*sb+b]) n = 3'(s);
      return n;
   endfunction
endpackage

// File: rtl/sde_h2c_axis_pkt_cnt.sv
// sde_h2c_axis_pkt_cnt: packet counter with write-back pulse and clear priority, shared with the C2H side.
// Define SDE_H2C_AXIS_BYTE_CNT_EN to add the 64-bit byte accumulator.
module sde_h2c_axis_pkt_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        inc_i,
`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
   input  logic        beat_i,
   input  logic [6:0]  bytes_i,
   output logic [63:0] byte_cnt_o,
`endif
   output logic [31:0] cnt_o,
   output logic        wb_req_o
);
   logic [31:0] cnt_q, cnt_d;
   logic        wb_q;

   assign cnt_d = clr_i ? '0 : cnt_q + 32'(inc_i);
   assign cnt_o = cnt_q;
   assign wb_req_o = wb_q;

   // The write-back pulse follows every last handshake even when a clear swallows the increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         wb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         wb_q <= inc_i;
      end
   end

`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
   logic [63:0] byte_q;

   assign byte_cnt_o = byte_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) byte_q <= '0;
      else byte_q <= clr_i ? '0 : byte_q + (beat_i ? 64'(bytes_i) : 64'd0);
   end
`endif
endmodule

// File: rtl/sde_h2c_axis_wc.sv
// sde_h2c_axis_wc: H2C AXIS egress; down-converts buffer beats to the user width and counts packets.
// Define SDE_H2C_AXIS_BYTE_CNT_EN to add the axis_cfg_byte_cnt output.
module sde_h2c_axis_wc
   import sde_h2c_axis_pkg::*;
#(
   parameter int DESC_TYPE = 0,
   parameter int PCIM_DATA_WIDTH = 512,
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int USER_BIT_WIDTH = DESC_TYPE ? 1 : 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_axis_clr_pkt_cnt,
`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
   output logic [63:0]                  axis_cfg_byte_cnt,
`endif
   output logic [31:0]                  axis_cfg_pkt_cnt,
   input  logic                         buf_axis_valid,
   input  logic [PCIM_DATA_WIDTH-1:0]   buf_axis_data,
   input  logic [PCIM_DATA_WIDTH/8-1:0] buf_axis_keep,
   input  logic [USER_BIT_WIDTH-1:0]    buf_axis_user,
   input  logic                         buf_axis_last,
   output logic                         axis_buf_ready,
   output logic                         h2c_axis_valid,
   output logic [AXIS_DATA_WIDTH-1:0]   h2c_axis_data,
   output logic [AXIS_DATA_WIDTH/8-1:0] h2c_axis_keep,
   output logic [USER_BIT_WIDTH-1:0]    h2c_axis_user,
   output logic                         h2c_axis_last,
   input  logic                         h2c_axis_ready,
   output logic                         axis_wb_pkt_cnt_req,
   output logic [31:0]                  axis_wb_pkt_cnt
);
   localparam int RATIO = f_ratio(PCIM_DATA_WIDTH, AXIS_DATA_WIDTH);
   localparam int SLICE_IDX_W = RATIO > 1 ? $clog2(RATIO) : 1;
   localparam int AKW = AXIS_DATA_WIDTH / 8;
   localparam int PKW = PCIM_DATA_WIDTH / 8;

   if (!f_legal_axis(AXIS_DATA_WIDTH) || PCIM_DATA_WIDTH % AXIS_DATA_WIDTH != 0 || RATIO > RATIO_MAX) begin : g_bad_width
      $error("sde_h2c_axis_wc: illegal PCIM/AXIS width combination");
   end

   state_e                   state_q;
   logic [SLICE_IDX_W-1:0]   idx_q, idx_d, nmax_q, nmax_d;
   logic [PCIM_DATA_WIDTH-1:0] hr_data_q, hr_data_d;
   logic [PKW-1:0]           hr_keep_q, hr_keep_d;
   logic                     hr_last_q, en_q, hs, fin;
   logic [31:0]              pkt_cnt;

   // HR shifts down one slice per handshake so the next slice always sits at bit 0.
   assign idx_d = idx_q + SLICE_IDX_W'(1);
   assign nmax_d = SLICE_IDX_W'(f_last_slice(KEEP_MAX'(buf_axis_keep), AKW, RATIO));
   assign hr_data_d = hr_data_q >> AXIS_DATA_WIDTH;
   assign hr_keep_d = hr_keep_q >> AKW;
   assign hs = h2c_axis_valid & h2c_axis_ready;
   assign fin = hs & (idx_q == nmax_q);
   assign axis_buf_ready = en_q & ((state_q == EMPTY) | fin);
   assign axis_cfg_pkt_cnt = pkt_cnt;
   assign axis_wb_pkt_cnt = pkt_cnt;

   // en_q keeps axis_buf_ready low while in reset and for the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         en_q <= 1'b0;
         idx_q <= '0;
         nmax_q <= '0;
         hr_data_q <= '0;
         hr_keep_q <= '0;
         hr_last_q <= 1'b0;
         h2c_axis_valid <= 1'b0;
         h2c_axis_data <= '0;
         h2c_axis_keep <= '0;
         h2c_axis_user <= '0;
         h2c_axis_last <= 1'b0;
      end else begin
         en_q <= 1'b1;
         if (buf_axis_valid && axis_buf_ready) begin
            state_q <= SEND;
            idx_q <= '0;
            nmax_q <= nmax_d;
            hr_data_q <= buf_axis_data;
            hr_keep_q <= buf_axis_keep;
            hr_last_q <= buf_axis_last;
            h2c_axis_valid <= 1'b1;
            h2c_axis_data <= buf_axis_data[AXIS_DATA_WIDTH-1:0];
            h2c_axis_keep <= buf_axis_keep[AKW-1:0];
            h2c_axis_user <= buf_axis_user;
            h2c_axis_last <= buf_axis_last & (nmax_d == '0);
         end else if (fin) begin
            state_q <= EMPTY;
            h2c_axis_valid <= 1'b0;
         end else if (hs) begin
            idx_q <= idx_d;
            hr_data_q <= hr_data_d;
            hr_keep_q <= hr_keep_d;
            h2c_axis_data <= hr_data_d[AXIS_DATA_WIDTH-1:0];
            h2c_axis_keep <= hr_keep_d[AKW-1:0];
            h2c_axis_last <= hr_last_q & (idx_d == nmax_q);
         end
      end
   end

   sde_h2c_axis_pkt_cnt u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (cfg_axis_clr_pkt_cnt),
      .inc_i      (hs & h2c_axis_last),
`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
      .beat_i     (hs),
      .bytes_i    (7'($countones(h2c_axis_keep))),
      .byte_cnt_o (axis_cfg_byte_cnt),
`endif
      .cnt_o      (pkt_cnt),
      .wb_req_o   (axis_wb_pkt_cnt_req)
   );
endmodule

// File: tb/tb_sde_h2c_axis_wc.sv
// tb_sde_h2c_axis_wc: scoreboard bench running four width configurations of sde_h2c_axis_wc side by side.
// Define SDE_H2C_AXIS_BYTE_CNT_EN to also check axis_cfg_byte_cnt.
module tb_sde_h2c_axis_wc;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input int w, input string n, input logic [511:0] a, input logic [511:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL w%0d %s: got %0h want %0h", w, n, a, e);
      end
   endtask

   task automatic fail(input int w, input string n);
      total++;
      bad++;
      $display("FAIL w%0d %s: got timeout want progress", w, n);
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [63:0] mk_keep(input int nb);
      logic [63:0] k;
      for (int i = 0; i < 64; i++) k[i] = i < nb;
      return k;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_w
      localparam int AW = g == 0 ? 512 : g == 1 ? 128 : g == 2 ? 64 : 256;
      localparam int R = 512 / AW;
      localparam int SB = AW / 8;

      logic rst_n = 1'b0, clr = 1'b0, fin_g = 1'b0;
      logic b_vld = 1'b0, b_lst = 1'b0, b_rdy;
      logic [511:0] b_dat = '0;
      logic [63:0] b_kep = '0, b_usr = '0;
      logic h_vld, h_lst, h_rdy = 1'b0, wb_req;
      logic [AW-1:0] h_dat;
      logic [SB-1:0] h_kep;
      logic [63:0] h_usr;
      logic [31:0] pkt, wb_cnt;
      logic [63:0] byte_cnt;
      logic rnd_en = 1'b0, rdy_frc = 1'b0;
      logic [AW-1:0] q_d[$];
      logic [SB-1:0] q_k[$];
      logic [63:0] q_u[$];
      logic q_l[$];
      logic [31:0] cnt_m = '0;
      logic [63:0] byt_m = '0;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pacc = 1'b0, ph = 1'b0;
      logic [AW-1:0] pd;
      logic [SB-1:0] pk;
      int sent_cyc = 0;

`ifndef SDE_H2C_AXIS_BYTE_CNT_EN
      assign byte_cnt = '0;
`endif

      sde_h2c_axis_wc #(.DESC_TYPE(0), .PCIM_DATA_WIDTH(512), .AXIS_DATA_WIDTH(AW)) u_dut (
         .clk                  (clk),
         .rst_n                (rst_n),
         .cfg_axis_clr_pkt_cnt (clr),
`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
         .axis_cfg_byte_cnt    (byte_cnt),
`endif
         .axis_cfg_pkt_cnt     (pkt),
         .buf_axis_valid       (b_vld),
         .buf_axis_data        (b_dat),
         .buf_axis_keep        (b_kep),
         .buf_axis_user        (b_usr),
         .buf_axis_last        (b_lst),
         .axis_buf_ready       (b_rdy),
         .h2c_axis_valid       (h_vld),
         .h2c_axis_data        (h_dat),
         .h2c_axis_keep        (h_kep),
         .h2c_axis_user        (h_usr),
         .h2c_axis_last        (h_lst),
         .h2c_axis_ready       (h_rdy),
         .axis_wb_pkt_cnt_req  (wb_req),
         .axis_wb_pkt_cnt      (wb_cnt)
      );

      initial forever begin
         @(posedge clk);
         #2;
         h_rdy = rnd_en ? ($urandom_range(3) != 0) : rdy_frc;
      end

      // Expected slices: a last beat yields ceil(bytes/slice) slices (at least one), any other beat all R.
      task automatic send(input logic [511:0] d, input int nb, input logic [63:0] u, input logic l);
         int n, cyc;
         logic ok;
         logic [63:0] k;
         n = l ? (nb + SB - 1) / SB : R;
         if (n == 0) n = 1;
         for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 64; i++) k[i] = i < SB && s * SB + i < nb;
            q_d.push_back(d[s*AW +: AW]);
            q_k.push_back(k[SB-1:0]);
            q_u.push_back(u);
            q_l.push_back(l && s == n - 1);
         end
         b_vld = 1'b1;
         b_dat = d;
         b_kep = mk_keep(nb);
         b_usr = u;
         b_lst = l;
         ok = 1'b0;
         cyc = 0;
         while (!ok && cyc < 200) begin
            @(negedge clk);
            ok = b_rdy;
            @(posedge clk);
            #1;
            cyc++;
         end
         if (!ok) fail(AW, "accept");
         sent_cyc += cyc;
         b_vld = 1'b0;
      endtask

      task automatic wait_idle();
         logic ok;
         ok = 1'b0;
         for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = q_d.size() == 0 && !h_vld;
         end
         if (!ok) fail(AW, "drain");
         @(posedge clk);
         #1;
      endtask

      task automatic clr_pulse();
         clr = 1'b1;
         @(posedge clk);
         #1;
         clr = 1'b0;
      endtask

      initial forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
            pl = 1'b0;
            pacc = 1'b0;
            cnt_m = '0;
            byt_m = '0;
         end else begin
            chk(AW, "pkt_cnt", 512'(pkt), 512'(cnt_m));
            chk(AW, "wb_cnt", 512'(wb_cnt), 512'(cnt_m));
            chk(AW, "wb_req", 512'(wb_req), 512'(pl));
`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
            chk(AW, "byte_cnt", 512'(byte_cnt), 512'(byt_m));
`endif
            if (pacc) chk(AW, "latency", 512'(h_vld), 512'(1));
            if (pv && !pr) begin
               chk(AW, "stall vld", 512'(h_vld), 512'(1));
               chk(AW, "stall data", 512'(h_dat), 512'(pd));
               chk(AW, "stall keep", 512'(h_kep), 512'(pk));
               chk(AW, "stall last", 512'(h_lst), 512'(ph));
            end
            if (h_vld && h_rdy) begin
               if (q_d.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL w%0d extra beat: got data %0h want none", AW, h_dat);
               end else begin
                  chk(AW, "data", 512'(h_dat), 512'(q_d.pop_front()));
                  chk(AW, "keep", 512'(h_kep), 512'(q_k.pop_front()));
                  chk(AW, "user", 512'(h_usr), 512'(q_u.pop_front()));
                  chk(AW, "last", 512'(h_lst), 512'(q_l.pop_front()));
               end
               byt_m += 64'($countones(h_kep));
            end
            pl = h_vld & h_rdy & h_lst;
            cnt_m = clr ? '0 : cnt_m + 32'(pl);
            if (clr) byt_m = '0;
            pv = h_vld;
            pr = h_rdy;
            pd = h_dat;
            pk = h_kep;
            ph = h_lst;
            pacc = b_vld & b_rdy;
         end
      end

      initial begin
         int k;
         int nx;
         logic [63:0] u;
         repeat (3) @(posedge clk);
         #1;
         chk(AW, "rst vld", 512'(h_vld), 512'(0));
         chk(AW, "rst data", 512'(h_dat), 512'(0));
         chk(AW, "rst last", 512'(h_lst), 512'(0));
         chk(AW, "rst buf_rdy", 512'(b_rdy), 512'(0));
         chk(AW, "rst pkt", 512'(pkt), 512'(0));
         rst_n = 1'b1;
         rdy_frc = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         sent_cyc = 0;
         for (int p = 0; p < 10; p++) send(rnd512(), 64, {$urandom, $urandom}, 1'b1);
         chk(AW, "burst cycles", 512'(sent_cyc), 512'(1 + 9 * R));
         wait_idle();
         chk(AW, "burst pkt", 512'(pkt), 512'(10));
         send(rnd512(), 64, 64'h1234, 1'b0);
         send(rnd512(), 20, 64'h1234, 1'b1);
         send(rnd512(), 0, 64'h55, 1'b1);
         rnd_en = 1'b1;
         for (int p = 0; p < 25; p++) begin
            nx = $urandom_range(3);
            u = {$urandom, $urandom};
            for (int b = 0; b < nx; b++) send(rnd512(), 64, u, 1'b0);
            send(rnd512(), int'($urandom_range(64)), u, 1'b1);
         end
         wait_idle();
         rnd_en = 1'b0;
         rdy_frc = 1'b0;
         send(rnd512(), 8, 64'h77, 1'b1);
         rdy_frc = 1'b1;
         clr_pulse();
         wait_idle();
         chk(AW, "clr on last", 512'(pkt), 512'(0));
`ifdef SDE_H2C_AXIS_BYTE_CNT_EN
         clr_pulse();
         for (int p = 0; p < 3; p++) begin
            send(rnd512(), 64, 64'h9, 1'b0);
            send(rnd512(), 36, 64'h9, 1'b1);
         end
         wait_idle();
         chk(AW, "byte 300", 512'(byte_cnt), 512'(300));
         clr_pulse();
         @(negedge clk);
         chk(AW, "byte clr", 512'(byte_cnt), 512'(0));
         @(posedge clk);
         #1;
`endif
         force u_dut.u_cnt.cnt_d = 32'hFFFF_FFFF;
         @(posedge clk);
         #1;
         release u_dut.u_cnt.cnt_d;
         cnt_m = 32'hFFFF_FFFF;
         chk(AW, "preload", 512'(pkt), 512'(32'hFFFF_FFFF));
         send(rnd512(), 64, 64'h3, 1'b1);
         wait_idle();
         chk(AW, "wrap", 512'(pkt), 512'(0));
         send(rnd512(), 64, 64'h3, 1'b1);
         wait_idle();
         rdy_frc = 1'b0;
         k = R / 2;
         send(rnd512(), 64, 64'h4, 1'b0);
         for (int s = k; s < R; s++) begin
            void'(q_d.pop_back());
            void'(q_k.pop_back());
            void'(q_u.pop_back());
            void'(q_l.pop_back());
         end
         rdy_frc = 1'b1;
         for (int s = 0; s < k; s++) @(posedge clk);
         #1;
         chk(AW, "abort sent", 512'(q_d.size()), 512'(0));
         rdy_frc = 1'b0;
         rst_n = 1'b0;
         #1;
         chk(AW, "abort vld", 512'(h_vld), 512'(0));
         chk(AW, "abort data", 512'(h_dat), 512'(0));
         chk(AW, "abort keep", 512'(h_kep), 512'(0));
         chk(AW, "abort last", 512'(h_lst), 512'(0));
         chk(AW, "abort buf_rdy", 512'(b_rdy), 512'(0));
         chk(AW, "abort pkt", 512'(pkt), 512'(0));
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         rnd_en = 1'b1;
         send(rnd512(), 64, 64'h5, 1'b0);
         send(rnd512(), 40, 64'h5, 1'b1);
         wait_idle();
         chk(AW, "post rst pkt", 512'(pkt), 512'(1));
         rnd_en = 1'b0;
         fin_g = 1'b1;
      end
   end

   initial begin
      logic all;
      all = 1'b0;
      for (int c = 0; c < 60000 && !all; c++) begin
         @(posedge clk);
         all = g_w[0].fin_g & g_w[1].fin_g & g_w[2].fin_g & g_w[3].fin_g;
      end
      if (!all) fail(0, "global");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
